// File: rtl/nibble_seq_ctrl.sv
// Sequences one operand pair through the shared nibble adder: a low pass, then a high pass, giving a 9-bit sum.
// Latency: accept at edge T, out_valid after edge T+2+2*STALL_CYC. Backpressure: the result is held in DONE until out_ready.
// Defining NIBSEQ_CNT_EN adds op_count, which counts completed result handshakes.
module nibble_seq_ctrl #(
  parameter int unsigned STALL_CYC = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  output logic [7:0] nib_A,
  output logic [7:0] nib_B,
  output logic       nib_ctrl,
  input  logic [4:0] nib_q,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] sum
`ifdef NIBSEQ_CNT_EN
  ,
  output logic [7:0] op_count
`endif
);

  localparam logic [3:0] STALL_LIM = 4'(STALL_CYC);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] q_lo_q, q_lo_d;
  logic [8:0] sum_q, sum_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] nib_a_q, nib_a_d;
  logic [7:0] nib_b_q, nib_b_d;
  logic       accept;
  logic       samp;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_lo_d      = q_lo_q;
    sum_d       = sum_q;
    out_valid_d = out_valid_q;
    nib_a_d     = nib_a_q;
    nib_b_d     = nib_b_q;
    in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept      = in_valid && in_ready;
    samp        = (cnt_q == STALL_LIM);

    case (state_q)
      IDLE: begin
        if (accept) begin
          nib_a_d = a_in;
          nib_b_d = b_in;
          cnt_d   = 4'd0;
          state_d = LO;
        end
      end
      LO: begin
        if (samp) begin
          q_lo_d  = nib_q;
          cnt_d   = 4'd0;
          state_d = HI;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HI: begin
        if (samp) begin
          // High partial is weighted by 16; the max total 510 fits in 9 bits.
          sum_d       = {nib_q, 4'b0000} + {4'b0000, q_lo_q};
          out_valid_d = 1'b1;
          cnt_d       = 4'd0;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            nib_a_d = a_in;
            nib_b_d = b_in;
            cnt_d   = 4'd0;
            state_d = LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      q_lo_q      <= 5'd0;
      sum_q       <= 9'd0;
      out_valid_q <= 1'b0;
      nib_a_q     <= 8'd0;
      nib_b_q     <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_lo_q      <= q_lo_d;
      sum_q       <= sum_d;
      out_valid_q <= out_valid_d;
      nib_a_q     <= nib_a_d;
      nib_b_q     <= nib_b_d;
    end
  end

  assign nib_A     = nib_a_q;
  assign nib_B     = nib_b_q;
  assign nib_ctrl  = (state_q == HI);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;

`ifdef NIBSEQ_CNT_EN
  logic [7:0] op_cnt_q, op_cnt_d;

  always_comb begin
    op_cnt_d = op_cnt_q + {7'd0, out_valid_q & out_ready};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= 8'd0;
    end else begin
      op_cnt_q <= op_cnt_d;
    end
  end

  assign op_count = op_cnt_q;
`endif

endmodule

// File: tb/tb_nibble_seq_ctrl.sv
// Directed bench: dut0 runs with STALL_CYC=0 and dut1 with STALL_CYC=3. Each DUT drives its own behavioural nibble adder.
module tb_nibble_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_valid_s, out_ready;
  logic [7:0] a_in, b_in;

  logic       in_ready0, nib_ctrl0, out_valid0;
  logic [7:0] nib_A0, nib_B0;
  logic [4:0] nib_q0;
  logic [8:0] sum0;

  logic       in_ready1, nib_ctrl1, out_valid1;
  logic [7:0] nib_A1, nib_B1;
  logic [4:0] nib_q1;
  logic [8:0] sum1;

`ifdef NIBSEQ_CNT_EN
  logic [7:0] op_count0, op_count1;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Behavioural model of the external nibble adder.
  assign nib_q0 = nib_ctrl0 ? ({1'b0, nib_A0[7:4]} + {1'b0, nib_B0[7:4]})
                            : ({1'b0, nib_A0[3:0]} + {1'b0, nib_B0[3:0]});
  assign nib_q1 = nib_ctrl1 ? ({1'b0, nib_A1[7:4]} + {1'b0, nib_B1[7:4]})
                            : ({1'b0, nib_A1[3:0]} + {1'b0, nib_B1[3:0]});

  nibble_seq_ctrl #(.STALL_CYC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .a_in(a_in), .b_in(b_in), .nib_A(nib_A0), .nib_B(nib_B0), .nib_ctrl(nib_ctrl0),
    .nib_q(nib_q0), .out_valid(out_valid0), .out_ready(out_ready), .sum(sum0)
`ifdef NIBSEQ_CNT_EN
    , .op_count(op_count0)
`endif
  );

  nibble_seq_ctrl #(.STALL_CYC(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready1),
    .a_in(a_in), .b_in(b_in), .nib_A(nib_A1), .nib_B(nib_B1), .nib_ctrl(nib_ctrl1),
    .nib_q(nib_q1), .out_valid(out_valid1), .out_ready(out_ready), .sum(sum1)
`ifdef NIBSEQ_CNT_EN
    , .op_count(op_count1)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full STALL_CYC=0 transaction on dut0 with out_ready held high.
  task automatic txn0(input logic [7:0] a, input logic [7:0] b, input logic [8:0] exp_sum);
    a_in = a; b_in = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("txn_ctrl_lo", {15'd0, nib_ctrl0}, 16'd0);
    step();
    chk("txn_ctrl_hi", {15'd0, nib_ctrl0}, 16'd1);
    step();
    chk("txn_valid", {15'd0, out_valid0}, 16'd1);
    chk("txn_sum", {7'd0, sum0}, {7'd0, exp_sum});
    step();
    chk("txn_valid_clr", {15'd0, out_valid0}, 16'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0; out_ready = 1'b1;
    a_in = 8'h00; b_in = 8'h00;
    #12;
    chk("rst_valid", {15'd0, out_valid0}, 16'd0);
    chk("rst_sum", {7'd0, sum0}, 16'd0);
    chk("rst_nibA", {8'd0, nib_A0}, 16'd0);
    chk("rst_ctrl", {15'd0, nib_ctrl0}, 16'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", {15'd0, in_ready0}, 16'd1);

    // First transaction, checked cycle by cycle.
    a_in = 8'h24; b_in = 8'h81; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("t1_nibA", {8'd0, nib_A0}, 16'h0024);
    chk("t1_nibB", {8'd0, nib_B0}, 16'h0081);
    chk("t1_ctrl0", {15'd0, nib_ctrl0}, 16'd0);
    chk("t1_busy", {15'd0, in_ready0}, 16'd0);
    chk("t1_nvalid", {15'd0, out_valid0}, 16'd0);
    step();
    chk("t1_ctrl1", {15'd0, nib_ctrl0}, 16'd1);
    step();
    chk("t1_valid", {15'd0, out_valid0}, 16'd1);
    chk("t1_sum", {7'd0, sum0}, 16'h00A5);
    chk("t1_ready_done", {15'd0, in_ready0}, 16'd1);
    step();
    chk("t1_valid_clr", {15'd0, out_valid0}, 16'd0);
    chk("t1_sum_hold", {7'd0, sum0}, 16'h00A5);

    txn0(8'hF9, 8'hC6, 9'h1BF);
    txn0(8'hFF, 8'hFF, 9'h1FE);

    // Backpressure; the next pair is presented but must not be taken.
    out_ready = 1'b0;
    a_in = 8'h0D; b_in = 8'h8D; in_valid = 1'b1;
    step();
    a_in = 8'h65; b_in = 8'h12;
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {15'd0, out_valid0}, 16'd1);
      chk("bp_sum", {7'd0, sum0}, 16'h009A);
      chk("bp_in_ready", {15'd0, in_ready0}, 16'd0);
      chk("bp_nibA", {8'd0, nib_A0}, 16'h000D);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {15'd0, in_ready0}, 16'd1);
    step();
    in_valid = 1'b0;
    chk("bp_same_edge_nibA", {8'd0, nib_A0}, 16'h0065);
    chk("bp_valid_clr", {15'd0, out_valid0}, 16'd0);
    step();
    step();
    chk("bp2_valid", {15'd0, out_valid0}, 16'd1);
    chk("bp2_sum", {7'd0, sum0}, 16'h0077);
    step();

    // Asynchronous reset while dut0 is in its high pass.
    a_in = 8'h33; b_in = 8'h44; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_ctrl_hi", {15'd0, nib_ctrl0}, 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum", {7'd0, sum0}, 16'd0);
    chk("mid_rst_valid", {15'd0, out_valid0}, 16'd0);
    chk("mid_rst_ctrl", {15'd0, nib_ctrl0}, 16'd0);
    chk("mid_rst_nibA", {8'd0, nib_A0}, 16'd0);
    #3;
    rst_n = 1'b1;
    step();
    chk("post_rst_ready", {15'd0, in_ready0}, 16'd1);
    txn0(8'h01, 8'h0D, 9'h00E);

    // STALL_CYC=3 on dut1: four cycles per pass, result after edge T+8.
    a_in = 8'h76; b_in = 8'h3D; in_valid_s = 1'b1;
    step();
    in_valid_s = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("st_ctrl_lo", {15'd0, nib_ctrl1}, 16'd0);
      chk("st_nvalid", {15'd0, out_valid1}, 16'd0);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      chk("st_ctrl_hi", {15'd0, nib_ctrl1}, 16'd1);
      chk("st_nvalid", {15'd0, out_valid1}, 16'd0);
      step();
    end
    chk("st_valid", {15'd0, out_valid1}, 16'd1);
    chk("st_sum", {7'd0, sum1}, 16'h00B3);
    step();
    chk("st_valid_clr", {15'd0, out_valid1}, 16'd0);

`ifdef NIBSEQ_CNT_EN
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    chk("cnt_rst", {8'd0, op_count0}, 16'd0);
    a_in = 8'h11; b_in = 8'h22; in_valid = 1'b1;
    step();
    for (int i = 0; i < 257 * 3; i++) step();
    in_valid = 1'b0;
    chk("cnt_wrap", {8'd0, op_count0}, 16'h0001);
    rst_n = 1'b0;
    #1;
    chk("cnt_rst2", {8'd0, op_count0}, 16'd0);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_seq_ctrl.md
Name: nibble_seq_ctrl

Overview:
- Sequencer for the shared nibble adder datapath. The adder takes A[7:0], B[7:0] and ctrl, and returns q[4:0]: ctrl=0 adds the low nibbles, ctrl=1 adds the high nibbles.
- Accepts one 8-bit operand pair per transaction over a valid/ready handshake.
- Runs the adder twice, low pass then high pass, and combines the two partial sums into a full 9-bit result.
- Sits between the operand source and the result consumer. The adder itself is instantiated outside this block.

Parameters:
- STALL_CYC, 0, extra wait cycles per pass before nib_q is sampled (legal range 0..15), for adder settling or a registered adder.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept an operand pair
- a_in  in  8  operand A
- b_in  in  8  operand B
- nib_A  out  8  to adder A
- nib_B  out  8  to adder B
- nib_ctrl  out  1  to adder ctrl (0=low pass, 1=high pass)
- nib_q  in  5  from adder q
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  9  a_in+b_in

Behaviour:
- Reset (async, rst_n=0), effective immediately, including mid-operation:
  - state=IDLE, out_valid=0, sum=0, nib_A=0, nib_B=0, nib_ctrl=0, wait counter=0.
  - In-flight operation is discarded.
- States and outputs:
  - IDLE, LO, HI, DONE.
  - in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational and reads 1 straight after reset release.
  - nib_A/nib_B are registered operand copies, held constant in all states until the next accept.
  - nib_ctrl=1 only in HI.
- Accept: in_valid && in_ready at a rising edge.
  - Latch a_in and b_in into nib_A and nib_B.
  - Clear the wait counter; state goes to LO.
- LO:
  - While wait counter < STALL_CYC, increment it each cycle.
  - When it equals STALL_CYC, on that edge capture q_lo=nib_q, clear the counter, go to HI.
- HI:
  - Same wait rule.
  - On the sampling edge: sum <= {nib_q,4'b0} + {4'b0,q_lo}, computed 9 bits wide (max 30*16+30=510, no overflow). Then out_valid<=1, state goes to DONE.
- DONE:
  - sum and out_valid are held stable until out_ready=1.
  - On that edge out_valid clears. If in_valid is also 1 the same edge accepts the new pair and goes to LO; otherwise go to IDLE.
- Latency and throughput:
  - Accept at edge T; out_valid is high after edge T+2+2*STALL_CYC.
  - Back-to-back throughput is one result per 3+2*STALL_CYC cycles.
- in_valid is ignored outside IDLE, and in DONE when out_ready=0. The source must hold its data.
- nib_q is sampled only on the LO and HI sampling edges and ignored otherwise.
- sum keeps its last value in IDLE.

Optional Feature:
- Macro NIBSEQ_CNT_EN.
- Defined:
  - Adds output op_count[7:0]: the number of completed result handshakes (out_valid && out_ready).
  - Reset value 0; wraps 0xFF->0x00.
  - Not cleared by any state transition, only by rst_n.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then a_in=8'h24, b_in=8'h81, STALL_CYC=0, out_ready=1:
  - in_ready=1 after reset.
  - nib_ctrl goes 0 then 1.
  - sum=9'h0A5 with out_valid high 3 cycles after accept.
- a_in=8'hF9, b_in=8'hC6 -> low pass q=15, high pass q=27 -> sum=9'h1BF. Then a_in=8'hFF, b_in=8'hFF -> sum=9'h1FE.
- Backpressure:
  - 8'h0D+8'h8D with out_ready=0 for 5 cycles: out_valid stays high, sum=9'h09A stable, in_ready=0.
  - Then out_ready=1 with in_valid=1 (8'h65+8'h12): same-edge accept; next sum=9'h077.
- STALL_CYC=3, 8'h76+8'h3D -> sum=9'h0B3, out_valid after edge T+8; nib_ctrl=0 for exactly 4 cycles.
- rst_n pulsed low during HI -> out_valid=0 and sum=0 immediately; the next accept (8'h01+8'h0D) yields 9'h00E.
- NIBSEQ_CNT_EN defined: 257 back-to-back transactions -> op_count=8'h01. Reset -> 8'h00.
